// File: rtl/falafel_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between falafel clients.
// Read responses return in order and are steered by an in-order ID FIFO.
package falafel_pkg;
  localparam int DATA_W = 32;
endpackage

module falafel_mem_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CLIENTS-1:0]             cl_req_val_i,
  output logic [NUM_CLIENTS-1:0]             cl_req_rdy_o,
  input  logic [NUM_CLIENTS-1:0]             cl_req_is_write_i,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0] cl_req_addr_i,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0] cl_req_data_i,
  output logic [NUM_CLIENTS-1:0]             cl_resp_val_o,
  input  logic [NUM_CLIENTS-1:0]             cl_resp_rdy_i,
  output logic [DATA_W-1:0]                  cl_resp_data_o,
  output logic                              mem_req_val_o,
  input  logic                              mem_req_rdy_i,
  output logic                              mem_req_is_write_o,
  output logic [DATA_W-1:0]                  mem_req_addr_o,
  output logic [DATA_W-1:0]                  mem_req_data_o,
  input  logic                              mem_resp_val_i,
  output logic                              mem_resp_rdy_o,
  input  logic [DATA_W-1:0]                  mem_resp_data_i,
  output logic                              err_o
);

  localparam int ID_W  = $clog2(NUM_CLIENTS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   win_q;
  logic [ID_W-1:0]   win_d;
  logic              is_write_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [NUM_CLIENTS-1:0] elig;
  logic                   found;
  logic                   grant;
  logic                   push;
  logic                   pop;
  logic                   nonempty;
  logic [ID_W-1:0]        head;

  function automatic logic [ID_W-1:0] wrap_add(
    input logic [ID_W-1:0] base,
    input int              off
  );
    int s;
    s = (int'(base) + off) % NUM_CLIENTS;
    return ID_W'(s);
  endfunction

  // Reads need a free FIFO slot; writes never produce a response.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig[i] = cl_req_val_i[i] &
        (cl_req_is_write_i[i] |
         (cnt_q < CNT_W'(MAX_OUTSTANDING)));
    end
  end

  always_comb begin
    found = 1'b0;
    win_d = rr_q;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!found && elig[wrap_add(rr_q, k)]) begin
        found = 1'b1;
        win_d = wrap_add(rr_q, k);
      end
    end
  end

  assign grant = (state_q == IDLE) & found;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_req_rdy_o[i] = grant & (win_d == ID_W'(i));
    end
  end

  assign head     = fifo_q[rd_q];
  assign nonempty = (cnt_q != '0);

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_resp_val_o[i] = mem_resp_val_i & nonempty &
                         (head == ID_W'(i));
    end
  end

  assign cl_resp_data_o = mem_resp_data_i;
  assign mem_resp_rdy_o = nonempty & cl_resp_rdy_i[head];
  assign pop  = mem_resp_val_i & mem_resp_rdy_o;
  assign push = grant & ~cl_req_is_write_i[win_d];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            is_write_q <= cl_req_is_write_i[win_d];
            addr_q     <= cl_req_addr_i[win_d];
            data_q     <= cl_req_data_i[win_d];
            win_q      <= win_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_rdy_i) begin
            rr_q    <= wrap_add(win_q, 1);
            state_q <= IDLE;
          end
        end
      endcase
      if (push) begin
        fifo_q[wr_q] <= win_d;
        wr_q         <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (mem_resp_val_i & ~nonempty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req_val_o      = (state_q == ISSUE);
  assign mem_req_is_write_o = is_write_q;
  assign mem_req_addr_o     = addr_q;
  assign mem_req_data_o     = data_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Scoreboard bench for falafel_mem_arbiter: directed stimulus pushes
// expected memory requests / client responses, a monitor pops and compares.
module tb_falafel_mem_arbiter;
  import falafel_pkg::*;

  localparam int N = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]             cl_req_val_i;
  logic [N-1:0]             cl_req_rdy_o;
  logic [N-1:0]             cl_req_is_write_i;
  logic [N-1:0][DATA_W-1:0] cl_req_addr_i;
  logic [N-1:0][DATA_W-1:0] cl_req_data_i;
  logic [N-1:0]             cl_resp_val_o;
  logic [N-1:0]             cl_resp_rdy_i;
  logic [DATA_W-1:0]        cl_resp_data_o;
  logic                    mem_req_val_o;
  logic                    mem_req_rdy_i;
  logic                    mem_req_is_write_o;
  logic [DATA_W-1:0]        mem_req_addr_o;
  logic [DATA_W-1:0]        mem_req_data_o;
  logic                    mem_resp_val_i;
  logic                    mem_resp_rdy_o;
  logic [DATA_W-1:0]        mem_resp_data_i;
  logic                    err_o;

  falafel_mem_arbiter #(
    .NUM_CLIENTS(N),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cl_req_val_i(cl_req_val_i),
    .cl_req_rdy_o(cl_req_rdy_o),
    .cl_req_is_write_i(cl_req_is_write_i),
    .cl_req_addr_i(cl_req_addr_i),
    .cl_req_data_i(cl_req_data_i),
    .cl_resp_val_o(cl_resp_val_o),
    .cl_resp_rdy_i(cl_resp_rdy_i),
    .cl_resp_data_o(cl_resp_data_o),
    .mem_req_val_o(mem_req_val_o),
    .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_is_write_o(mem_req_is_write_o),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_resp_val_i(mem_resp_val_i),
    .mem_resp_rdy_o(mem_resp_rdy_o),
    .mem_resp_data_i(mem_resp_data_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [95:0] exp_req[$];
  logic [95:0] exp_resp[$];

  function automatic logic [95:0] pack_req(
    input logic w, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d
  );
    return 96'({w, a, d});
  endfunction

  function automatic logic [95:0] pack_resp(
    input int c, input logic [DATA_W-1:0] d
  );
    return 96'({8'(c), d});
  endfunction

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected or never happened", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_val_o && mem_req_rdy_i) begin
        if (exp_req.size() == 0) fail("mem_req_unexpected");
        else check("mem_req",
          pack_req(mem_req_is_write_o, mem_req_addr_o, mem_req_data_o),
          exp_req.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (cl_resp_val_o[i] && cl_resp_rdy_i[i]) begin
          if (exp_resp.size() == 0) fail("cl_resp_unexpected");
          else check("cl_resp", pack_resp(i, cl_resp_data_o),
                     exp_resp.pop_front());
        end
      end
    end
  end

  task automatic drained();
    check("req_q_empty", 96'(exp_req.size()), 96'(0));
    check("resp_q_empty", 96'(exp_resp.size()), 96'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cl_req_val_i = '0;
    cl_req_is_write_i = '0;
    cl_req_addr_i = '0;
    cl_req_data_i = '0;
    cl_resp_rdy_i = '1;
    mem_req_rdy_i = 1'b1;
    mem_resp_val_i = 1'b0;
    mem_resp_data_i = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send(input int c, input logic w,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    cl_req_val_i[c] = 1'b1;
    cl_req_is_write_i[c] = w;
    cl_req_addr_i[c] = a;
    cl_req_data_i[c] = d;
    exp_req.push_back(pack_req(w, a, d));
    #1;
    while (!cl_req_rdy_o[c] && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) fail("send_timeout");
    cyc();
    cl_req_val_i[c] = 1'b0;
  endtask

  task automatic resp(input int c, input logic [DATA_W-1:0] d);
    int n = 0;
    mem_resp_val_i = 1'b1;
    mem_resp_data_i = d;
    exp_resp.push_back(pack_resp(c, d));
    #1;
    while (!mem_resp_rdy_o && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) fail("resp_timeout");
    cyc();
    mem_resp_val_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] g;
    do_reset();
    // reset state
    #1;
    check("rst_mem_val", 96'(mem_req_val_o), 96'(0));
    check("rst_mem_regs",
      pack_req(mem_req_is_write_o, mem_req_addr_o, mem_req_data_o), 96'(0));
    check("rst_cl_rdy", 96'(cl_req_rdy_o), 96'(0));
    check("rst_resp", 96'({cl_resp_val_o, mem_resp_rdy_o, err_o}), 96'(0));

    // single read then response
    send(0, 1'b0, 32'h40, 32'h0);
    #1;
    check("t1_val_next", 96'(mem_req_val_o), 96'(1));
    check("t1_addr", 96'({mem_req_is_write_o, mem_req_addr_o}), 96'(32'h40));
    cyc();
    #1;
    check("t1_val_drop", 96'(mem_req_val_o), 96'(0));
    mem_resp_val_i = 1'b1;
    mem_resp_data_i = 32'hDEAD;
    exp_resp.push_back(pack_resp(0, 32'hDEAD));
    #1;
    check("t1_route", 96'(cl_resp_val_o), 96'(2'b01));
    cyc();
    mem_resp_val_i = 1'b0;

    // round-robin with both clients always valid
    drained();
    do_reset();
    exp_req.push_back(pack_req(1'b1, 32'h100, 32'hA0));
    exp_req.push_back(pack_req(1'b1, 32'h200, 32'hA1));
    exp_req.push_back(pack_req(1'b1, 32'h100, 32'hA0));
    exp_req.push_back(pack_req(1'b1, 32'h200, 32'hA1));
    cl_req_is_write_i = 2'b11;
    cl_req_addr_i[0] = 32'h100;
    cl_req_addr_i[1] = 32'h200;
    cl_req_data_i[0] = 32'hA0;
    cl_req_data_i[1] = 32'hA1;
    cl_req_val_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      g = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
      check("t2_grant", 96'(cl_req_rdy_o), 96'(g));
      cyc();
    end
    cl_req_val_i = 2'b00;
    cyc();

    // outstanding limit blocks reads, not writes
    drained();
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 1'b0, 32'h10 + 32'(k), 32'h0);
    cyc();
    cl_req_val_i[0] = 1'b1;
    cl_req_is_write_i[0] = 1'b0;
    cl_req_addr_i[0] = 32'h14;
    cl_req_data_i[0] = 32'h0;
    #1;
    check("t3_c0_blocked", 96'(cl_req_rdy_o), 96'(0));
    send(1, 1'b1, 32'h80, 32'h55);
    #1;
    check("t3_write_issue", 96'({mem_req_val_o, mem_req_addr_o}),
          96'({1'b1, 32'h80}));
    cyc();
    mem_resp_val_i = 1'b1;
    mem_resp_data_i = 32'h1111;
    exp_resp.push_back(pack_resp(0, 32'h1111));
    #1;
    check("t3_pop_rdy", 96'(mem_resp_rdy_o), 96'(1));
    check("t3_pop_no_free", 96'(cl_req_rdy_o), 96'(0));
    cyc();
    mem_resp_val_i = 1'b0;
    #1;
    check("t3_unblocked", 96'(cl_req_rdy_o), 96'(2'b01));
    exp_req.push_back(pack_req(1'b0, 32'h14, 32'h0));
    cyc();
    cl_req_val_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) resp(0, 32'h2000 + 32'(k));

    // response backpressure and in-order routing
    drained();
    do_reset();
    send(1, 1'b0, 32'h300, 32'h0);
    send(0, 1'b0, 32'h304, 32'h0);
    cyc();
    cl_resp_rdy_i = 2'b01;
    mem_resp_val_i = 1'b1;
    mem_resp_data_i = 32'hB1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_mem_rdy_low", 96'(mem_resp_rdy_o), 96'(0));
      check("t4_val_c1", 96'(cl_resp_val_o), 96'(2'b10));
      cyc();
    end
    cl_resp_rdy_i = 2'b11;
    exp_resp.push_back(pack_resp(1, 32'hB1));
    #1;
    check("t4_mem_rdy_high", 96'(mem_resp_rdy_o), 96'(1));
    cyc();
    mem_resp_data_i = 32'hB0;
    exp_resp.push_back(pack_resp(0, 32'hB0));
    #1;
    check("t4_val_c0", 96'(cl_resp_val_o), 96'(2'b01));
    cyc();
    mem_resp_val_i = 1'b0;

    // memory stall in ISSUE
    drained();
    do_reset();
    mem_req_rdy_i = 1'b0;
    send(0, 1'b1, 32'h500, 32'hCAFE);
    cl_req_val_i[1] = 1'b1;
    cl_req_addr_i[1] = 32'h504;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_stable",
        pack_req(mem_req_is_write_o, mem_req_addr_o, mem_req_data_o) |
          (96'(mem_req_val_o) << 80),
        pack_req(1'b1, 32'h500, 32'hCAFE) | (96'(1) << 80));
      check("t5_no_rdy", 96'(cl_req_rdy_o), 96'(0));
      cyc();
    end
    mem_req_rdy_i = 1'b1;
    cl_req_val_i[1] = 1'b0;
    #1;
    check("t5_val_c4", 96'(mem_req_val_o), 96'(1));
    cyc();
    #1;
    check("t5_accepted", 96'(mem_req_val_o), 96'(0));

    // reset while in ISSUE with reads outstanding
    drained();
    do_reset();
    send(0, 1'b0, 32'h600, 32'h0);
    send(1, 1'b0, 32'h604, 32'h0);
    cyc();
    mem_req_rdy_i = 1'b0;
    send(0, 1'b1, 32'h608, 32'h77);
    #1;
    check("t6_in_issue", 96'(mem_req_val_o), 96'(1));
    exp_req.delete();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mem_req_rdy_i = 1'b1;
    #1;
    check("t6_val_dropped", 96'(mem_req_val_o), 96'(0));
    check("t6_fifo_empty", 96'(mem_resp_rdy_o), 96'(0));
    check("t6_err_clear", 96'(err_o), 96'(0));
    mem_resp_val_i = 1'b1;
    mem_resp_data_i = 32'hEE;
    #1;
    check("t6_resp_rdy_low", 96'(mem_resp_rdy_o), 96'(0));
    check("t6_no_route", 96'(cl_resp_val_o), 96'(0));
    cyc();
    mem_resp_val_i = 1'b0;
    #1;
    check("t6_err_set", 96'(err_o), 96'(1));
    cyc();
    cyc();
    #1;
    check("t6_err_sticky", 96'(err_o), 96'(1));
    check("t6_no_replay", 96'(mem_req_val_o), 96'(0));

    drained();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
